// File: rtl/udp_frame_pattern_gen_pkg.sv
// Shared types and helpers for the UDP test-frame pattern generator.
// Holds the FSM state enum, header sizing, PRBS-9 constants and a saturating add.
package udp_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } state_e;

  // Channel-id byte that precedes the sequence bytes.
  localparam int HDR_CH_BYTES = 1;

  // PRBS-9, x^9 + x^5 + 1: feedback from bits 8 and 4.
  localparam logic [8:0] PRBS9_SEED  = 9'h1FF;
  localparam int         PRBS9_TAP_A = 8;
  localparam int         PRBS9_TAP_B = 4;

  function automatic int hdr_len(input int seq_w);
    return HDR_CH_BYTES + seq_w / 8;
  endfunction

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/udp_frame_pattern_gen_if.sv
// Byte-stream (AXI-Stream style) link out of the pattern generator.
// master drives tdata/tvalid/tlast/tuser, slave drives tready.
interface udp_frame_pattern_gen_if #(
  parameter int CH_W = 2
);
  logic [7:0]      tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [CH_W-1:0] tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/udp_frame_pattern_gen_prbs9.sv
// udp_prbs9_byte: PRBS-9 (x^9+x^5+1) source producing 8 bits per step.
// load_i seeds, step_i advances 8 bits; byte_o is the next byte (first bit in MSB).
module udp_prbs9_byte
  import udp_test_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [8:0] seed_i,
  output logic [7:0] byte_o
);

  logic [8:0] lfsr_q;
  logic [8:0] lfsr_d;
  logic       fb;

  always_comb begin
    lfsr_d = lfsr_q;
    byte_o = '0;
    fb     = 1'b0;
    for (int b = 0; b < 8; b++) begin
      fb     = lfsr_d[PRBS9_TAP_A] ^ lfsr_d[PRBS9_TAP_B];
      byte_o = {byte_o[6:0], fb};
      lfsr_d = {lfsr_d[7:0], fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       lfsr_q <= PRBS9_SEED;
    else if (load_i) lfsr_q <= seed_i;
    else if (step_i) lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/udp_frame_pattern_gen.sv
// udp_frame_pattern_gen: round-robin test-frame source over N_CH channels.
// Frame = [ch id][seq bytes, MSB first][payload]; payload is seq[7:0]+i,
// or PRBS-9 when UDP_PATGEN_PRBS_EN is defined.
// Ports: sys_clk/sys_rst (sync, active-high), link_up, start/stop pulses,
// cfg_len/cfg_gap/cfg_frames (latched at start), m (stream master),
// busy, done (1-cycle), frames_sent (saturating).
module udp_frame_pattern_gen
  import udp_test_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 4,
  parameter  int LEN_W  = 11,
  parameter  int SEQ_W  = 16,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             link_up,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [7:0]       cfg_gap,
  input  logic [15:0]      cfg_frames,
  udp_frame_pattern_gen_if.master m,
  output logic             busy,
  output logic             done,
  output logic [31:0]      frames_sent
);

  localparam int SEQ_B = SEQ_W / 8;
  localparam int IDX_W = 16;
  localparam logic [IDX_W-1:0] HDR_LEN = IDX_W'(hdr_len(SEQ_W));

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [SEQ_W-1:0]  seq_q [N_CH];
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  last_idx_q;
  logic [7:0]        gap_q;
  logic [7:0]        gap_cnt_q;
  logic [15:0]       nframes_q;
  logic              stop_pend_q;
  logic [DATA_W-1:0] tdata_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic [CH_W-1:0]   tuser_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       frames_q;

  logic              hs;
  logic [SEQ_W-1:0]  cur_seq;
  logic [IDX_W-1:0]  idx_d;
  logic [CH_W-1:0]   ch_d;
  logic [31:0]       frames_d;
  logic [LEN_W-1:0]  len_eff;
  logic [7:0]        pay_byte;
  logic [7:0]        byte_d;
  logic              end_run;

  assign hs       = tvalid_q & m.tready;
  assign cur_seq  = seq_q[ch_q];
  assign idx_d    = idx_q + 1'b1;
  assign ch_d     = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
  assign frames_d = sat_add32(frames_q, 32'd1);
  assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

  // Run ends after the frame whose tlast is handshaking now.
  assign end_run = stop_pend_q | stop | ~link_up |
                   ((nframes_q != '0) &&
                    (frames_d == {16'h0, nframes_q}));

`ifdef UDP_PATGEN_PRBS_EN
  logic prbs_load;
  logic prbs_step;
  logic [7:0] prbs_byte;

  // Reseed while the header is on the wire; step per payload byte loaded.
  assign prbs_step = hs & ~tlast_q & (idx_d >= HDR_LEN);
  assign prbs_load = (state_q == ST_HDR) & ~prbs_step;

  udp_prbs9_byte u_prbs (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .load_i (prbs_load),
    .step_i (prbs_step),
    .seed_i (PRBS9_SEED ^ {1'b0, cur_seq[7:0]}),
    .byte_o (prbs_byte)
  );

  assign pay_byte = prbs_byte;
`else
  assign pay_byte = cur_seq[7:0] + 8'(idx_d - HDR_LEN);
`endif

  // Byte to present after the current one is accepted.
  always_comb begin
    byte_d = pay_byte;
    for (int k = 0; k < SEQ_B; k++) begin
      if (idx_d == IDX_W'(k + 1))
        byte_d = cur_seq[SEQ_W-1-8*k -: 8];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      nframes_q   <= '0;
      stop_pend_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frames_q    <= '0;
      for (int c = 0; c < N_CH; c++)
        seq_q[c] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && link_up) begin
            last_idx_q  <= HDR_LEN - 1'b1 + IDX_W'(len_eff);
            gap_q       <= cfg_gap;
            nframes_q   <= cfg_frames;
            frames_q    <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_HDR;
            idx_q       <= '0;
            tvalid_q    <= 1'b1;
            tlast_q     <= 1'b0;
            tdata_q     <= DATA_W'(ch_q);
            tuser_q     <= ch_q;
          end
        end
        ST_HDR, ST_PAYLOAD: begin
          if (stop) stop_pend_q <= 1'b1;
          if (hs && tlast_q) begin
            seq_q[ch_q] <= cur_seq + 1'b1;
            ch_q        <= ch_d;
            frames_q    <= frames_d;
            tlast_q     <= 1'b0;
            if (end_run) begin
              state_q  <= ST_IDLE;
              tvalid_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else if (gap_q == 8'd0) begin
              state_q <= ST_HDR;
              idx_q   <= '0;
              tdata_q <= DATA_W'(ch_d);
              tuser_q <= ch_d;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_q;
              tvalid_q  <= 1'b0;
            end
          end else if (hs) begin
            idx_q   <= idx_d;
            tdata_q <= byte_d;
            tlast_q <= (idx_d == last_idx_q);
            if (idx_d >= HDR_LEN) state_q <= ST_PAYLOAD;
          end
        end
        ST_GAP: begin
          if (stop || !link_up) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == 8'd1) begin
            state_q  <= ST_HDR;
            idx_q    <= '0;
            tvalid_q <= 1'b1;
            tdata_q  <= DATA_W'(ch_q);
            tuser_q  <= ch_q;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m.tdata     = tdata_q;
  assign m.tvalid    = tvalid_q;
  assign m.tlast     = tlast_q;
  assign m.tuser     = tuser_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_udp_frame_pattern_gen.sv
// Bench for udp_frame_pattern_gen: random stimulus vs a frame-level model.
// Second instance (N_CH=1, SEQ_W=8) exercises sequence wrap.
module tb_udp_frame_pattern_gen;

  localparam int N_CH = 4;
  localparam int HB   = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        link_up = 1'b0;
  logic        start   = 1'b0;
  logic        start2  = 1'b0;
  logic        stop    = 1'b0;
  logic        stop2   = 1'b0;
  logic [10:0] cfg_len = '0;
  logic [7:0]  cfg_gap = '0;
  logic [15:0] cfg_frames = '0;
  logic        busy, done, busy2, done2;
  logic [31:0] frames_sent, frames_sent2;
  logic        rnd = 1'b0;

  udp_frame_pattern_gen_if #(.CH_W(2)) m1 ();
  udp_frame_pattern_gen_if #(.CH_W(1)) m2 ();

  always #4 sys_clk = ~sys_clk;

  udp_frame_pattern_gen #(.N_CH(4), .SEQ_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .link_up(link_up),
    .start(start), .stop(stop), .cfg_len(cfg_len),
    .cfg_gap(cfg_gap), .cfg_frames(cfg_frames), .m(m1),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  udp_frame_pattern_gen #(.N_CH(1), .SEQ_W(8)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .link_up(link_up),
    .start(start2), .stop(stop2), .cfg_len(cfg_len),
    .cfg_gap(cfg_gap), .cfg_frames(cfg_frames), .m(m2),
    .busy(busy2), .done(done2), .frames_sent(frames_sent2)
  );

  typedef struct packed {
    logic [3:0] u;
    logic       l;
    logic [7:0] d;
  } beat_t;

  int compared = 0;
  int mismatched = 0;
  beat_t cap1[$], exp1[$], cap2[$], exp2[$];
  int cyc1[$];
  int cyc = 0;
  int done1_cnt = 0, done2_cnt = 0, done_cyc = 0;
  int stall_err = 0;
  logic stall_prev = 1'b0;
  logic [11:0] stall_val;
  logic [15:0] mseq [N_CH];
  int mch = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (m1.tvalid && m1.tready) begin
      cap1.push_back(beat_t'{u: 4'(m1.tuser), l: m1.tlast, d: m1.tdata});
      cyc1.push_back(cyc);
    end
    if (stall_prev &&
        {m1.tvalid, m1.tlast, m1.tuser, m1.tdata} !== stall_val)
      stall_err++;
    stall_prev = m1.tvalid && !m1.tready && !sys_rst;
    stall_val  = {m1.tvalid, m1.tlast, m1.tuser, m1.tdata};
    if (done) begin done1_cnt++; done_cyc = cyc; end
    if (m2.tvalid && m2.tready)
      cap2.push_back(beat_t'{u: 4'(m2.tuser), l: m2.tlast, d: m2.tdata});
    if (done2) done2_cnt++;
  end

  function automatic logic [7:0] pay_byte(logic [7:0] s8, int i);
`ifdef UDP_PATGEN_PRBS_EN
    logic [8:0] r = 9'h1FF ^ {1'b0, s8};
    logic [7:0] b = '0;
    logic nb;
    for (int k = 0; k <= i; k++)
      for (int j = 0; j < 8; j++) begin
        nb = r[8] ^ r[4];
        r  = {r[7:0], nb};
        b  = {b[6:0], nb};
      end
    return b;
`else
    return s8 + 8'(i);
`endif
  endfunction

  function automatic void model_frame1(int len);
    int n = (len == 0) ? 1 : len;
    logic [15:0] s = mseq[mch];
    exp1.push_back(beat_t'{u: 4'(mch), l: 1'b0, d: 8'(mch)});
    exp1.push_back(beat_t'{u: 4'(mch), l: 1'b0, d: s[15:8]});
    exp1.push_back(beat_t'{u: 4'(mch), l: 1'b0, d: s[7:0]});
    for (int i = 0; i < n; i++)
      exp1.push_back(beat_t'{u: 4'(mch), l: (i == n - 1), d: pay_byte(s[7:0], i)});
    mseq[mch] = s + 16'd1;
    mch = (mch + 1) % N_CH;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
    m1.tready = rnd ? 1'($urandom % 2) : 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_q();
    cap1.delete();
    exp1.delete();
    cyc1.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) step();
    compared++; if (m1.tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_tvalid got=%b want=0", m1.tvalid); end
    compared++; if (m1.tlast !== 1'b0) begin mismatched++; $display("FAIL rst_tlast got=%b want=0", m1.tlast); end
    compared++; if (m1.tdata !== 8'h00) begin mismatched++; $display("FAIL rst_tdata got=%h want=00", m1.tdata); end
    compared++; if (m1.tuser !== 2'd0) begin mismatched++; $display("FAIL rst_tuser got=%0d want=0", m1.tuser); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%b want=0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done got=%b want=0", done); end
    compared++; if (frames_sent !== 32'd0) begin mismatched++; $display("FAIL rst_frames got=%0d want=0", frames_sent); end
    compared++; if (m2.tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_tvalid2 got=%b want=0", m2.tvalid); end
    sys_rst = 1'b0;
    link_up = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d0 = done1_cnt;
    rnd = 1'b0;
    clear_q();
    cfg_len = 11'd4; cfg_gap = 8'd2; cfg_frames = 16'd3;
    pulse_start();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy got=%b want=1", busy); end
    repeat (3) model_frame1(4);
    for (int i = 0; i < 200 && done1_cnt == d0; i++) step();
    compared++; if (done1_cnt == d0) begin mismatched++; $display("FAIL basic_done_timeout got=%0d want=%0d", done1_cnt, d0 + 1); end
    compared++; if (cap1.size() != exp1.size()) begin mismatched++; $display("FAIL basic_len got=%0d want=%0d", cap1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      compared++; if (cap1[i] !== exp1[i]) begin mismatched++; $display("FAIL basic_byte[%0d] got=%h want=%h", i, cap1[i], exp1[i]); end
    end
    if (cyc1.size() == 21) begin
      compared++; if (cyc1[7] - cyc1[6] != 3) begin mismatched++; $display("FAIL basic_gap1 got=%0d want=3", cyc1[7] - cyc1[6]); end
      compared++; if (cyc1[14] - cyc1[13] != 3) begin mismatched++; $display("FAIL basic_gap2 got=%0d want=3", cyc1[14] - cyc1[13]); end
      compared++; if (done_cyc != cyc1[20] + 1) begin mismatched++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc, cyc1[20] + 1); end
    end
    step();
    compared++; if (frames_sent !== 32'd3) begin mismatched++; $display("FAIL basic_frames got=%0d want=3", frames_sent); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_end got=%b want=0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_stall();
    int d0 = done1_cnt;
    int len = $urandom_range(1, 12);
    clear_q();
    stall_err = 0;
    rnd = 1'b1;
    cfg_len = 11'(len); cfg_gap = 8'($urandom_range(0, 3)); cfg_frames = 16'd5;
    pulse_start();
    repeat (5) model_frame1(len);
    for (int i = 0; i < 3000 && done1_cnt == d0; i++) step();
    rnd = 1'b0;
    compared++; if (done1_cnt == d0) begin mismatched++; $display("FAIL stall_done_timeout got=%0d want=%0d", done1_cnt, d0 + 1); end
    compared++; if (cap1.size() != exp1.size()) begin mismatched++; $display("FAIL stall_len got=%0d want=%0d", cap1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      compared++; if (cap1[i] !== exp1[i]) begin mismatched++; $display("FAIL stall_byte[%0d] got=%h want=%h", i, cap1[i], exp1[i]); end
    end
    compared++; if (stall_err != 0) begin mismatched++; $display("FAIL stall_hold got=%0d want=0", stall_err); end
    compared++; if (frames_sent !== 32'd5) begin mismatched++; $display("FAIL stall_frames got=%0d want=5", frames_sent); end
    step();
  endtask

  task automatic test_stop();
    int d0 = done1_cnt;
    clear_q();
    cfg_len = 11'd8; cfg_gap = 8'd1; cfg_frames = 16'd0;
    pulse_start();
    for (int i = 0; i < 1000 && cap1.size() < 5 * 11 + HB + 2; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (6) model_frame1(8);
    for (int i = 0; i < 200 && done1_cnt == d0; i++) step();
    compared++; if (done1_cnt == d0) begin mismatched++; $display("FAIL stop_done_timeout got=%0d want=%0d", done1_cnt, d0 + 1); end
    repeat (20) step();
    compared++; if (cap1.size() != exp1.size()) begin mismatched++; $display("FAIL stop_len got=%0d want=%0d", cap1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      compared++; if (cap1[i] !== exp1[i]) begin mismatched++; $display("FAIL stop_byte[%0d] got=%h want=%h", i, cap1[i], exp1[i]); end
    end
    compared++; if (frames_sent !== 32'd6) begin mismatched++; $display("FAIL stop_frames got=%0d want=6", frames_sent); end
    compared++; if (m1.tvalid !== 1'b0) begin mismatched++; $display("FAIL stop_tvalid got=%b want=0", m1.tvalid); end
  endtask

  task automatic test_stop_gap();
    int d0 = done1_cnt;
    clear_q();
    cfg_len = 11'd2; cfg_gap = 8'd30; cfg_frames = 16'd0;
    pulse_start();
    model_frame1(2);
    for (int i = 0; i < 100 && cap1.size() < 5; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 2 && done1_cnt == d0; i++) step();
    compared++; if (done1_cnt == d0) begin mismatched++; $display("FAIL gapstop_done got=%0d want=%0d", done1_cnt, d0 + 1); end
    repeat (40) step();
    compared++; if (cap1.size() != 5) begin mismatched++; $display("FAIL gapstop_len got=%0d want=5", cap1.size()); end
    compared++; if (frames_sent !== 32'd1) begin mismatched++; $display("FAIL gapstop_frames got=%0d want=1", frames_sent); end
  endtask

  task automatic test_link();
    int d0;
    clear_q();
    link_up = 1'b0;
    cfg_len = 11'd6; cfg_gap = 8'd0; cfg_frames = 16'd0;
    pulse_start();
    repeat (5) step();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL link_down_busy got=%b want=0", busy); end
    compared++; if (m1.tvalid !== 1'b0) begin mismatched++; $display("FAIL link_down_tvalid got=%b want=0", m1.tvalid); end
    link_up = 1'b1;
    d0 = done1_cnt;
    pulse_start();
    model_frame1(6);
    for (int i = 0; i < 100 && cap1.size() < 3; i++) step();
    link_up = 1'b0;
    for (int i = 0; i < 200 && done1_cnt == d0; i++) step();
    compared++; if (done1_cnt == d0) begin mismatched++; $display("FAIL link_done_timeout got=%0d want=%0d", done1_cnt, d0 + 1); end
    repeat (5) step();
    compared++; if (cap1.size() != exp1.size()) begin mismatched++; $display("FAIL link_len got=%0d want=%0d", cap1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      compared++; if (cap1[i] !== exp1[i]) begin mismatched++; $display("FAIL link_byte[%0d] got=%h want=%h", i, cap1[i], exp1[i]); end
    end
    compared++; if (frames_sent !== 32'd1) begin mismatched++; $display("FAIL link_frames got=%0d want=1", frames_sent); end
    link_up = 1'b1;
    step();
  endtask

  task automatic test_len0_start_stop();
    int d0 = done1_cnt;
    clear_q();
    cfg_len = 11'd0; cfg_gap = 8'd0; cfg_frames = 16'd2;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (2) model_frame1(0);
    for (int i = 0; i < 100 && done1_cnt == d0; i++) step();
    compared++; if (done1_cnt == d0) begin mismatched++; $display("FAIL len0_done_timeout got=%0d want=%0d", done1_cnt, d0 + 1); end
    compared++; if (cap1.size() != exp1.size()) begin mismatched++; $display("FAIL len0_len got=%0d want=%0d", cap1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      compared++; if (cap1[i] !== exp1[i]) begin mismatched++; $display("FAIL len0_byte[%0d] got=%h want=%h", i, cap1[i], exp1[i]); end
    end
    compared++; if (frames_sent !== 32'd2) begin mismatched++; $display("FAIL len0_frames got=%0d want=2", frames_sent); end
    step();
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_q();
    cfg_len = 11'd10; cfg_gap = 8'd0; cfg_frames = 16'd0;
    pulse_start();
    for (int i = 0; i < 100 && cap1.size() < 20; i++) step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    compared++; if (m1.tvalid !== 1'b0) begin mismatched++; $display("FAIL rstmid_tvalid got=%b want=0", m1.tvalid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    compared++; if (frames_sent !== 32'd0) begin mismatched++; $display("FAIL rstmid_frames got=%0d want=0", frames_sent); end
    for (int c = 0; c < N_CH; c++) mseq[c] = '0;
    mch = 0;
    step();
    clear_q();
    d0 = done1_cnt;
    cfg_len = 11'd3; cfg_frames = 16'd1;
    pulse_start();
    model_frame1(3);
    for (int i = 0; i < 100 && done1_cnt == d0; i++) step();
    compared++; if (cap1.size() != exp1.size()) begin mismatched++; $display("FAIL rstmid_len got=%0d want=%0d", cap1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      compared++; if (cap1[i] !== exp1[i]) begin mismatched++; $display("FAIL rstmid_byte[%0d] got=%h want=%h", i, cap1[i], exp1[i]); end
    end
  endtask

  task automatic test_seq_wrap();
    int d0 = done2_cnt;
    cap2.delete();
    exp2.delete();
    cfg_len = 11'd1; cfg_gap = 8'd0; cfg_frames = 16'd257;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 257; k++) begin
      exp2.push_back(beat_t'{u: 4'd0, l: 1'b0, d: 8'h00});
      exp2.push_back(beat_t'{u: 4'd0, l: 1'b0, d: 8'(k)});
      exp2.push_back(beat_t'{u: 4'd0, l: 1'b1, d: pay_byte(8'(k), 0)});
    end
    for (int i = 0; i < 2000 && done2_cnt == d0; i++) step();
    compared++; if (done2_cnt == d0) begin mismatched++; $display("FAIL wrap_done_timeout got=%0d want=%0d", done2_cnt, d0 + 1); end
    compared++; if (cap2.size() != exp2.size()) begin mismatched++; $display("FAIL wrap_len got=%0d want=%0d", cap2.size(), exp2.size()); end
    for (int i = 0; i < exp2.size() && i < cap2.size(); i++) begin
      compared++; if (cap2[i] !== exp2[i]) begin mismatched++; $display("FAIL wrap_byte[%0d] got=%h want=%h", i, cap2[i], exp2[i]); end
    end
    if (cap2.size() == 771) begin
      compared++; if (cap2[766].d !== 8'hFF) begin mismatched++; $display("FAIL wrap_seq_ff got=%h want=ff", cap2[766].d); end
      compared++; if (cap2[769].d !== 8'h00) begin mismatched++; $display("FAIL wrap_seq_00 got=%h want=00", cap2[769].d); end
    end
    step();
    compared++; if (frames_sent2 !== 32'd257) begin mismatched++; $display("FAIL wrap_frames got=%0d want=257", frames_sent2); end
  endtask

  initial begin
    m1.tready = 1'b1;
    m2.tready = 1'b1;
    for (int c = 0; c < N_CH; c++) mseq[c] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_stop();
    test_stop_gap();
    test_link();
    test_len0_start_stop();
    test_reset_mid();
    test_seq_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
